seven_segment_scan: RTL and testbench
=====================================

SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8; number of multiplexed digits, legal range 1..16.
REQ-002 SHALL have parameter CLK_PER, default 10; clock period in ns.
REQ-003 SHALL have parameter REFR_RATE, default 1000; full-frame refresh rate in Hz.
REQ-004 SHALL have parameter BRIGHT_W, default 4; brightness code width.
REQ-005 SHALL have parameter GUARD_CYC, default 16; anti-ghost dark cycles before each digit.
REQ-006 SHALL derive DIGIT_CYC = 1e9/(CLK_PER*REFR_RATE*NUM_DIGITS), integer division; 12500 at defaults.
REQ-007 SHALL fail elaboration unless DIGIT_CYC > GUARD_CYC + 2**BRIGHT_W.
REQ-008 SHALL have ports as follows (clock and reset first).
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = drive the display; 0 = force all outputs dark.
- load  input  1  1-cycle strobe; captures digits/dp/blank into the shadow buffer.
- digits  input  4*NUM_DIGITS  hex nibble per digit; digit i = bits [4i+3:4i].
- dp  input  NUM_DIGITS  decimal point per digit; 1 = lit.
- blank  input  NUM_DIGITS  per-digit blank; 1 = digit dark.
- brightness  input  BRIGHT_W  PWM duty code.
- anode  output  NUM_DIGITS  active-low digit select, registered.
- cathode  output  8  active-low segments, registered; [0]=a .. [6]=g, [7]=dp.
- frame_start  output  1  1-cycle pulse at the start of digit 0.
- pending  output  1  shadow holds data not yet transferred to active.

Function
REQ-009 SHALL scan digits 0,1,..,NUM_DIGITS-1 and wrap to 0, each digit slot lasting exactly DIGIT_CYC cycles.
REQ-010 SHALL run a two-state FSM per slot: GUARD for GUARD_CYC cycles, then ON for DIGIT_CYC-GUARD_CYC cycles; ON->GUARD advances the digit index.
REQ-011 SHALL, in GUARD, drive anode all 1s and cathode 8'hFF.
REQ-012 SHALL, in ON, run pwm_cnt (BRIGHT_W bits) from 0 at ON entry, incrementing mod 2**BRIGHT_W; current anode bit driven 0 only while active_brightness > pwm_cnt, all other anode bits 1.
REQ-013 SHALL mean brightness 0 = digit never lit and all-ones = duty (2**BRIGHT_W-1)/2**BRIGHT_W.
REQ-014 SHALL decode the active nibble to the standard hex glyphs, active-low, dp clear: 0->8'hC0, 1->8'hF9, 8->8'h80, A->8'h88, F->8'h8E; a lit dp clears bit 7.
REQ-015 SHALL make a blanked digit's cathode 8'hFF, including dp, while still consuming its slot.
REQ-016 SHALL register outputs: anode/cathode reflect FSM state and counters with exactly 1 cycle latency.
REQ-017 SHALL, on load=1, write digits/dp/blank into the shadow buffer and set pending=1; for back-to-back loads the last one wins.
REQ-018 SHALL, on the frame-boundary cycle (first GUARD cycle of digit 0), copy shadow to active when pending=1, clear pending, and sample brightness into active_brightness.
REQ-019 SHALL, when load coincides with the frame-boundary cycle, copy the pre-load shadow, update shadow with the new data and leave pending=1 for the next frame.
REQ-020 SHALL never let the displayed content change mid-frame.
REQ-021 SHALL assert frame_start on the registered output in the same cycle anode/cathode show digit 0's first GUARD cycle.
REQ-022 SHALL, with enable=0, keep the scan FSM, counters and buffer transfers running and force anode all 1s and cathode 8'hFF; enable rising resumes mid-scan with no restart.

Reset
REQ-023 SHALL, on reset=1 at a clock edge, set anode all 1s, cathode 8'hFF, frame_start 0, pending 0, digit index 0, state GUARD, all counters 0, shadow and active digits/dp 0, blank all 1s, active_brightness 0.
REQ-024 SHALL let reset override load and enable, abort any slot immediately, and start the first frame (frame_start=1) on the second cycle after reset deasserts.

Verification (NUM_DIGITS=4, CLK_PER=10, REFR_RATE=390625 -> DIGIT_CYC=64, GUARD_CYC=4, BRIGHT_W=2)
REQ-025 SHALL check: reset, load digits=16'h8F10, dp=0, blank=0, brightness=3 -> from next frame, digit0 cathode C0, digit1 F9, digit2 8E, digit3 80; each anode low 45 of 60 ON cycles.
REQ-026 SHALL check: brightness=0 -> anode all 1s for entire frame; brightness=1 -> 15 low cycles per digit in a 1-of-4 pattern.
REQ-027 SHALL check: load mid-frame then new load on the frame-boundary cycle -> first data shown that frame, second data the next frame, pending=1 in between.
REQ-028 SHALL check: blank=4'b0100, dp=4'b0001 -> digit2 cathode FF throughout, digit0 bit7=0; frame_start period 256 cycles; 4 dark cycles before every digit.
REQ-029 SHALL check: enable=0 mid-frame, then reset mid-slot -> outputs dark immediately; after reset, blank display and frame_start on the second cycle.

Source files
------------

// File: rtl/seven_segment_scan.sv
// Multiplexed seven-segment scanner: per-digit guard/ON slots, PWM brightness,
// double-buffered digit data that only changes at frame boundaries.
module seven_segment_scan #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_PER    = 10,
  parameter int REFR_RATE  = 1000,
  parameter int BRIGHT_W   = 4,
  parameter int GUARD_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int DIGIT_CYC = 1000000000 / (CLK_PER * REFR_RATE * NUM_DIGITS);
  localparam int ON_CYC    = DIGIT_CYC - GUARD_CYC;
  localparam int CNT_W     = $clog2(DIGIT_CYC);
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  if (DIGIT_CYC <= GUARD_CYC + 2**BRIGHT_W) begin : g_badTiming
    $error("seven_segment_scan: DIGIT_CYC must exceed GUARD_CYC + 2**BRIGHT_W");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_badDigits
    $error("seven_segment_scan: NUM_DIGITS must be 1..16");
  end

  logic [0:0]              state_q, state_d;
  logic [IDX_W-1:0]        digitIdx_q, digitIdx_d;
  logic [CNT_W-1:0]        phaseCnt_q, phaseCnt_d;
  logic [BRIGHT_W-1:0]     pwmCnt_q, pwmCnt_d;
  logic [4*NUM_DIGITS-1:0] shadowDigits_q, shadowDigits_d, activeDigits_q, activeDigits_d;
  logic [NUM_DIGITS-1:0]   shadowDp_q, shadowDp_d, activeDp_q, activeDp_d;
  logic [NUM_DIGITS-1:0]   shadowBlank_q, shadowBlank_d, activeBlank_q, activeBlank_d;
  logic [BRIGHT_W-1:0]     activeBright_q, activeBright_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]              cathode_q, cathode_d;
  logic                    frameStart_q, frameStart_d;
  logic                    frameBoundary;
  logic [3:0]              curNib;

  function automatic logic [7:0] hexGlyph(input logic [3:0] nib);
    case (nib)
      4'h0: hexGlyph = 8'hC0;
      4'h1: hexGlyph = 8'hF9;
      4'h2: hexGlyph = 8'hA4;
      4'h3: hexGlyph = 8'hB0;
      4'h4: hexGlyph = 8'h99;
      4'h5: hexGlyph = 8'h92;
      4'h6: hexGlyph = 8'h82;
      4'h7: hexGlyph = 8'hF8;
      4'h8: hexGlyph = 8'h80;
      4'h9: hexGlyph = 8'h90;
      4'hA: hexGlyph = 8'h88;
      4'hB: hexGlyph = 8'h83;
      4'hC: hexGlyph = 8'hC6;
      4'hD: hexGlyph = 8'hA1;
      4'hE: hexGlyph = 8'h86;
      default: hexGlyph = 8'h8E;
    endcase
  endfunction

  assign frameBoundary = (state_q == ST_GUARD) && (digitIdx_q == '0) && (phaseCnt_q == '0);
  assign curNib        = activeDigits_q[{digitIdx_q, 2'b00} +: 4];

  always_comb begin
    state_d    = state_q;
    digitIdx_d = digitIdx_q;
    phaseCnt_d = phaseCnt_q;
    pwmCnt_d   = pwmCnt_q;
    if (state_q == ST_GUARD) begin
      if (phaseCnt_q == CNT_W'(GUARD_CYC - 1)) begin
        state_d    = ST_ON;
        phaseCnt_d = '0;
        pwmCnt_d   = '0;
      end else begin
        phaseCnt_d = phaseCnt_q + 1'b1;
      end
    end else begin
      pwmCnt_d = pwmCnt_q + 1'b1;
      if (phaseCnt_q == CNT_W'(ON_CYC - 1)) begin
        state_d    = ST_GUARD;
        phaseCnt_d = '0;
        digitIdx_d = (digitIdx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digitIdx_q + 1'b1;
      end else begin
        phaseCnt_d = phaseCnt_q + 1'b1;
      end
    end
  end

  // Transfer happens before the load update so a coinciding load stays pending.
  always_comb begin
    shadowDigits_d = shadowDigits_q;
    shadowDp_d     = shadowDp_q;
    shadowBlank_d  = shadowBlank_q;
    activeDigits_d = activeDigits_q;
    activeDp_d     = activeDp_q;
    activeBlank_d  = activeBlank_q;
    activeBright_d = activeBright_q;
    pending_d      = pending_q;
    if (frameBoundary) begin
      activeBright_d = brightness;
      if (pending_q) begin
        activeDigits_d = shadowDigits_q;
        activeDp_d     = shadowDp_q;
        activeBlank_d  = shadowBlank_q;
        pending_d      = 1'b0;
      end
    end
    if (load) begin
      shadowDigits_d = digits;
      shadowDp_d     = dp;
      shadowBlank_d  = blank;
      pending_d      = 1'b1;
    end
  end

  always_comb begin
    anode_d      = '1;
    cathode_d    = 8'hFF;
    frameStart_d = frameBoundary;
    if (enable && state_q == ST_ON) begin
      if (activeBright_q > pwmCnt_q) begin
        anode_d[digitIdx_q] = 1'b0;
      end
      if (!activeBlank_q[digitIdx_q]) begin
        cathode_d = hexGlyph(curNib) & {~activeDp_q[digitIdx_q], 7'h7F};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_GUARD;
      digitIdx_q     <= '0;
      phaseCnt_q     <= '0;
      pwmCnt_q       <= '0;
      shadowDigits_q <= '0;
      shadowDp_q     <= '0;
      shadowBlank_q  <= '1;
      activeDigits_q <= '0;
      activeDp_q     <= '0;
      activeBlank_q  <= '1;
      activeBright_q <= '0;
      pending_q      <= 1'b0;
      anode_q        <= '1;
      cathode_q      <= 8'hFF;
      frameStart_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      digitIdx_q     <= digitIdx_d;
      phaseCnt_q     <= phaseCnt_d;
      pwmCnt_q       <= pwmCnt_d;
      shadowDigits_q <= shadowDigits_d;
      shadowDp_q     <= shadowDp_d;
      shadowBlank_q  <= shadowBlank_d;
      activeDigits_q <= activeDigits_d;
      activeDp_q     <= activeDp_d;
      activeBlank_q  <= activeBlank_d;
      activeBright_q <= activeBright_d;
      pending_q      <= pending_d;
      anode_q        <= anode_d;
      cathode_q      <= cathode_d;
      frameStart_q   <= frameStart_d;
    end
  end

  assign anode       = anode_q;
  assign cathode     = cathode_q;
  assign frame_start = frameStart_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Frame-level scoreboard bench for seven_segment_scan: 4 digits, 64-cycle slots,
// 4 guard cycles, 2-bit brightness, 256-cycle frames.
module tb_seven_segment_scan;

  localparam int ND    = 4;
  localparam int SLOT  = 64;
  localparam int GUARD = 4;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        reset, enable, load;
  logic [15:0] digits;
  logic [3:0]  dp, blank;
  logic [1:0]  brightness;
  logic [3:0]  anode;
  logic [7:0]  cathode;
  logic        frame_start, pending;

  int testsRun = 0;
  int testsFailed = 0;
  int nextBright = -1;

  typedef struct {
    logic [15:0] dg;
    logic [3:0]  dpv;
    logic [3:0]  bl;
    int          bright;
    int          pend;
  } frame_t;

  typedef struct {
    int          at;
    logic [15:0] dg;
    logic [3:0]  dpv;
    logic [3:0]  bl;
  } load_t;

  frame_t expQ[$];
  load_t  loadPlan[$];

  seven_segment_scan #(
    .NUM_DIGITS(4), .CLK_PER(10), .REFR_RATE(390625), .BRIGHT_W(2), .GUARD_CYC(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .digits(digits), .dp(dp), .blank(blank), .brightness(brightness),
    .anode(anode), .cathode(cathode), .frame_start(frame_start), .pending(pending)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] expCath(input logic [3:0] nib, input logic dpBit, input logic blBit);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    if (blBit) return 8'hFF;
    return dpBit ? (g & 8'h7F) : g;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushFrame(input logic [15:0] dg, input logic [3:0] dpv, input logic [3:0] bl,
                           input int br, input int pend);
    frame_t e;
    e.dg = dg; e.dpv = dpv; e.bl = bl; e.bright = br; e.pend = pend;
    expQ.push_back(e);
  endtask

  task automatic planLoad(input int at, input logic [15:0] dg, input logic [3:0] dpv, input logic [3:0] bl);
    load_t l;
    l.at = at; l.dg = dg; l.dpv = dpv; l.bl = bl;
    loadPlan.push_back(l);
  endtask

  // Entered at the negedge where frame_start is visible; leaves at the next one.
  task automatic applyStimulus(input string tag);
    frame_t     e;
    logic [7:0] cath[ND];
    int         lowCnt[ND];
    int         patErr[ND];
    int         stableErr = 0, guardErr = 0, selErr = 0, fsErr = 0;
    int         d, off, k;
    logic       lit;
    testsRun++;
    assert (expQ.size() > 0) else begin
      testsFailed++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end
    if (expQ.size() == 0) return;
    e = expQ.pop_front();
    for (int j = 0; j < ND; j++) begin
      cath[j] = 8'hXX; lowCnt[j] = 0; patErr[j] = 0;
    end
    checkOutput({tag, " fsAtStart"}, frame_start, 1);
    for (int t = 0; t < FRAME; t++) begin
      if (t > 0) @(negedge clk);
      load = 1'b0;
      if (loadPlan.size() > 0 && loadPlan[0].at == t) begin
        digits = loadPlan[0].dg; dp = loadPlan[0].dpv; blank = loadPlan[0].bl;
        load = 1'b1;
        void'(loadPlan.pop_front());
      end
      if (t == 200 && nextBright >= 0) begin
        brightness = 2'(nextBright);
        nextBright = -1;
      end
      if (t == 128 && e.pend >= 0) checkOutput({tag, " pending"}, pending, e.pend);
      d = t / SLOT;
      off = t % SLOT;
      if (t > 0 && frame_start !== 1'b0) fsErr++;
      if (off < GUARD) begin
        if (anode !== 4'hF || cathode !== 8'hFF) guardErr++;
      end else begin
        k = off - GUARD;
        lit = (e.bright > (k % 4));
        for (int j = 0; j < ND; j++)
          if (j != d && anode[j] !== 1'b1) selErr++;
        if (anode[d] !== !lit) patErr[d]++;
        if (anode[d] === 1'b0) lowCnt[d]++;
        if (k == 0) cath[d] = cathode;
        else if (cathode !== cath[d]) stableErr++;
      end
    end
    @(negedge clk);
    load = 1'b0;
    checkOutput({tag, " period"}, frame_start, 1);
    for (int j = 0; j < ND; j++) begin
      checkOutput($sformatf("%s cath%0d", tag, j), cath[j],
                  expCath(e.dg[4*j +: 4], e.dpv[j], e.bl[j]));
      checkOutput($sformatf("%s lowCnt%0d", tag, j), lowCnt[j], 15 * e.bright);
      checkOutput($sformatf("%s pwmPattern%0d", tag, j), patErr[j], 0);
    end
    checkOutput({tag, " guardDark"}, guardErr, 0);
    checkOutput({tag, " otherAnodes"}, selErr, 0);
    checkOutput({tag, " cathStable"}, stableErr, 0);
    checkOutput({tag, " fsSingle"}, fsErr, 0);
  endtask

  initial begin
    int darkErr;
    reset = 1'b1; enable = 1'b1; load = 1'b1;
    digits = 16'h1234; dp = 4'h0; blank = 4'h0; brightness = 2'd0;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset anode", anode, 4'hF);
    checkOutput("reset cathode", cathode, 8'hFF);
    checkOutput("reset frameStart", frame_start, 0);
    checkOutput("reset pending", pending, 0);
    reset = 1'b0;
    checkOutput("deassert fs0", frame_start, 0);
    @(negedge clk);

    // Blank first frame; 8F10 loaded mid-frame with brightness 3 for the next.
    pushFrame(16'h0000, 4'h0, 4'hF, 0, 1);
    planLoad(100, 16'h8F10, 4'h0, 4'h0);
    nextBright = 3;
    applyStimulus("f0 blankAfterReset");

    pushFrame(16'h8F10, 4'h0, 4'h0, 3, 0);
    nextBright = 0;
    applyStimulus("f1 bright3");

    pushFrame(16'h8F10, 4'h0, 4'h0, 0, 0);
    nextBright = 1;
    applyStimulus("f2 bright0");

    // Mid-frame load A, then load B exactly on the frame-boundary cycle.
    pushFrame(16'h8F10, 4'h0, 4'h0, 1, 1);
    planLoad(100, 16'h1080, 4'h0, 4'h0);
    planLoad(FRAME - 1, 16'h0A18, 4'h0, 4'h0);
    applyStimulus("f3 bright1");

    pushFrame(16'h1080, 4'h0, 4'h0, 1, 1);
    applyStimulus("f4 showA");

    pushFrame(16'h0A18, 4'h0, 4'h0, 1, 0);
    planLoad(150, 16'h0A18, 4'b0001, 4'b0100);
    nextBright = 2;
    applyStimulus("f5 showB");

    pushFrame(16'h0A18, 4'b0001, 4'b0100, 2, 0);
    applyStimulus("f6 blankDp");

    // Frame 7: disable mid-slot while digit 1 is lit.
    repeat (68) @(negedge clk);
    checkOutput("f7 litBeforeDisable", anode, 4'b1101);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("disable anode", anode, 4'hF);
    checkOutput("disable cathode", cathode, 8'hFF);
    darkErr = 0;
    for (int t = 70; t < FRAME; t++) begin
      @(negedge clk);
      if (anode !== 4'hF || cathode !== 8'hFF) darkErr++;
    end
    checkOutput("disabled dark", darkErr, 0);
    @(negedge clk);
    checkOutput("disabled fsPeriod", frame_start, 1);

    // Frame 8: reset mid-slot, overriding enable and load.
    repeat (100) @(negedge clk);
    reset = 1'b1; enable = 1'b1; load = 1'b1; digits = 16'hFFFF; blank = 4'h0;
    @(negedge clk);
    load = 1'b0;
    checkOutput("midReset anode", anode, 4'hF);
    checkOutput("midReset cathode", cathode, 8'hFF);
    checkOutput("midReset pending", pending, 0);
    checkOutput("midReset fs", frame_start, 0);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("postReset fs0", frame_start, 0);
    @(negedge clk);
    pushFrame(16'h0000, 4'h0, 4'hF, 2, 0);
    applyStimulus("f9 afterReset");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
